// File: rtl/cheshire_rst_boot_sequencer.sv
// Board-level reset/boot sequencer for the Cheshire FPGA top.
// It synchronizes the asynchronous board inputs and debounces the cpu_reset button.
// It waits for clock lock and holds the SoC in reset for a fixed time before releasing it.
// On release it latches the boot-mode and test-mode switches.
// Loss of lock, a button press or a debug ndmreset request re-sequences the reset.
module cheshire_rst_boot_sequencer #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 1024,
  parameter int HoldCycles     = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       rst_btn_i,
  input  logic       ndmreset_req_i,
  input  logic [1:0] boot_mode_sw_i,
  input  logic       test_mode_sw_i,
  output logic       sys_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       test_mode_o,
  output logic [1:0] rst_cause_o,
  output logic       rst_done_o
);

  localparam logic [1:0] LOCK = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_NDM  = 2'd2;
  localparam logic [1:0] CAUSE_LOCK = 2'd3;

  localparam int SyncW = 5;
  localparam int DbW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int HcW   = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

  localparam logic [DbW-1:0] DbLast   = DbW'(DebounceCycles - 1);
  localparam logic [HcW-1:0] HoldLast = HcW'(HoldCycles - 1);

  // Synchronizer chain: all async inputs share one shift register, oldest stage at the top.
  logic [SyncStages-1:0][SyncW-1:0] sync_q;
  logic                             locked_s;
  logic                             btn_s;
  logic [1:0]                       boot_mode_sw_s;
  logic                             test_mode_sw_s;

  assign {locked_s, btn_s, boot_mode_sw_s, test_mode_sw_s} = sync_q[SyncStages-1];

  // Shift the raw inputs through SyncStages flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values, as real flops do.
      sync_q <= {sync_q[SyncStages-2:0],
                 {pll_locked_i, rst_btn_i, boot_mode_sw_i, test_mode_sw_i}};
    end
  end

  // Debounce: accept a new button level only after DebounceCycles consecutive differing cycles.
  logic           btn_db_q;
  logic [DbW-1:0] db_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else if (btn_s == btn_db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbLast) begin
      btn_db_q <= btn_s;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DbW'(1);
    end
  end

  // Sequencer FSM state.
  logic [1:0]     state_q, state_d;
  logic [HcW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]     cause_d;
  logic           release_evt;

  // Next-state logic. Exit priority is lock loss, then button, then ndmreset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = rst_cause_o;
    unique case (state_q)
      LOCK: begin
        if (locked_s) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = LOCK;
          cause_d = CAUSE_LOCK;
        end else if (btn_db_q || ndmreset_req_i) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HcW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = LOCK;
          cause_d = CAUSE_LOCK;
        end else if (btn_db_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          cause_d    = CAUSE_BTN;
        end else if (ndmreset_req_i) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          cause_d    = CAUSE_NDM;
        end
      end
      default: begin
        state_d = LOCK;
      end
    endcase
  end

  assign release_evt = (state_q == HOLD) && (state_d == RUN);

  // FSM registers and registered outputs. The switches are captured only on the release edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: every register here is reset. The SoC reads these outputs while still in reset, so X is not acceptable.
      state_q     <= LOCK;
      hold_cnt_q  <= '0;
      sys_rst_no  <= 1'b0;
      boot_mode_o <= 2'b00;
      test_mode_o <= 1'b0;
      rst_cause_o <= 2'd0;
      rst_done_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sys_rst_no  <= (state_d == RUN);
      rst_cause_o <= cause_d;
      rst_done_o  <= release_evt;
      if (release_evt) begin
        boot_mode_o <= boot_mode_sw_s;
        test_mode_o <= test_mode_sw_s;
      end
    end
  end

endmodule

// File: tb/tb_cheshire_rst_boot_sequencer.sv
// Directed testbench for cheshire_rst_boot_sequencer.
// Parameters: SyncStages=2, DebounceCycles=16, HoldCycles=64.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_cheshire_rst_boot_sequencer;

  logic       clk_i;
  logic       rst_ni;
  logic       pll_locked_i;
  logic       rst_btn_i;
  logic       ndmreset_req_i;
  logic [1:0] boot_mode_sw_i;
  logic       test_mode_sw_i;
  logic       sys_rst_no;
  logic [1:0] boot_mode_o;
  logic       test_mode_o;
  logic [1:0] rst_cause_o;
  logic       rst_done_o;

  int checks = 0;
  int errors = 0;
  int n;

  cheshire_rst_boot_sequencer #(
    .SyncStages    (2),
    .DebounceCycles(16),
    .HoldCycles    (64)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pll_locked_i  (pll_locked_i),
    .rst_btn_i     (rst_btn_i),
    .ndmreset_req_i(ndmreset_req_i),
    .boot_mode_sw_i(boot_mode_sw_i),
    .test_mode_sw_i(test_mode_sw_i),
    .sys_rst_no    (sys_rst_no),
    .boot_mode_o   (boot_mode_o),
    .test_mode_o   (test_mode_o),
    .rst_cause_o   (rst_cause_o),
    .rst_done_o    (rst_done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk_i);
  endtask

  // Count the rising clock edges until sys_rst_no reaches the given level, giving up at limit.
  task automatic wait_level(input logic level, input int limit, output int edges);
    edges = 0;
    while (sys_rst_no !== level && edges < limit) begin
      @(negedge clk_i);
      edges++;
    end
  endtask

  initial begin
    rst_ni         = 1'b0;
    pll_locked_i   = 1'b1;
    rst_btn_i      = 1'b0;
    ndmreset_req_i = 1'b0;
    boot_mode_sw_i = 2'b10;
    test_mode_sw_i = 1'b1;

    // Power-on reset: all outputs must be at their reset values.
    #1;
    check("por_sys_rst_no", 32'(sys_rst_no), 0);
    check("por_boot_mode", 32'(boot_mode_o), 0);
    check("por_test_mode", 32'(test_mode_o), 0);
    check("por_cause", 32'(rst_cause_o), 0);
    check("por_rst_done", 32'(rst_done_o), 0);
    tick(2);

    // Test 1: lock is already present at release, so sys_rst_no rises at edge 2+1+64.
    rst_ni = 1'b1;
    wait_level(1'b1, 200, n);
    check("t1_release_edge", 32'(n), 67);
    check("t1_rst_done_hi", 32'(rst_done_o), 1);
    check("t1_boot_mode", 32'(boot_mode_o), 2);
    check("t1_test_mode", 32'(test_mode_o), 1);
    check("t1_cause", 32'(rst_cause_o), 0);
    tick(1);
    check("t1_rst_done_lo", 32'(rst_done_o), 0);

    // Test 2: a 5-cycle glitch is shorter than the debounce window and is ignored.
    rst_btn_i = 1'b1;
    tick(5);
    rst_btn_i = 1'b0;
    tick(40);
    check("t2_glitch_ignored", 32'(sys_rst_no), 1);
    // A real press drops sys_rst_no after 2+16+1 edges.
    rst_btn_i = 1'b1;
    wait_level(1'b0, 100, n);
    check("t2_press_latency", 32'(n), 19);
    check("t2_cause", 32'(rst_cause_o), 1);
    tick(21);
    check("t2_held_in_reset", 32'(sys_rst_no), 0);
    // The debounced button falls 18 edges after release, then the full hold is 64 more edges.
    rst_btn_i = 1'b0;
    wait_level(1'b1, 200, n);
    check("t2_release_edge", 32'(n), 82);
    check("t2_rst_done", 32'(rst_done_o), 1);

    // Test 3: a 1-cycle ndmreset request resets on the next edge, and the switches change during HOLD.
    ndmreset_req_i = 1'b1;
    tick(1);
    ndmreset_req_i = 1'b0;
    check("t3_ndm_reset", 32'(sys_rst_no), 0);
    check("t3_cause", 32'(rst_cause_o), 2);
    boot_mode_sw_i = 2'b01;
    test_mode_sw_i = 1'b0;
    wait_level(1'b1, 200, n);
    check("t3_release_edge", 32'(n), 64);
    check("t3_boot_mode", 32'(boot_mode_o), 1);
    check("t3_test_mode", 32'(test_mode_o), 0);
    check("t3_cause_kept", 32'(rst_cause_o), 2);

    // Test 5: switch changes while in RUN do not reach the outputs.
    boot_mode_sw_i = 2'b11;
    test_mode_sw_i = 1'b1;
    tick(10);
    check("t5_boot_mode_kept", 32'(boot_mode_o), 1);
    check("t5_test_mode_kept", 32'(test_mode_o), 0);
    check("t5_still_run", 32'(sys_rst_no), 1);

    // Test 4: line up the rising edge of the debounced button with the falling edge of the synchronized lock.
    // Both happen at edge 18, and lock loss must win at edge 19.
    rst_btn_i = 1'b1;
    tick(16);
    pll_locked_i = 1'b0;
    tick(2);
    check("t4_edge18_run", 32'(sys_rst_no), 1);
    tick(1);
    check("t4_edge19_reset", 32'(sys_rst_no), 0);
    check("t4_cause_priority", 32'(rst_cause_o), 3);
    rst_btn_i = 1'b0;
    tick(30);
    check("t4_stay_lock", 32'(sys_rst_no), 0);
    pll_locked_i = 1'b1;
    wait_level(1'b1, 200, n);
    check("t4_relock_release", 32'(n), 67);
    check("t4_cause_kept", 32'(rst_cause_o), 3);
    check("t4_boot_mode", 32'(boot_mode_o), 3);

    // Test 6: assert rst_ni at HOLD count 30, which resets everything asynchronously.
    ndmreset_req_i = 1'b1;
    tick(1);
    ndmreset_req_i = 1'b0;
    check("t6_in_hold", 32'(rst_cause_o), 2);
    tick(30);
    rst_ni = 1'b0;
    #1;
    check("t6_async_sys_rst", 32'(sys_rst_no), 0);
    check("t6_async_boot_mode", 32'(boot_mode_o), 0);
    check("t6_async_test_mode", 32'(test_mode_o), 0);
    check("t6_async_cause", 32'(rst_cause_o), 0);
    check("t6_async_rst_done", 32'(rst_done_o), 0);
    tick(2);
    rst_ni = 1'b1;
    wait_level(1'b1, 200, n);
    check("t6_reseq_release", 32'(n), 67);
    check("t6_boot_mode", 32'(boot_mode_o), 3);
    check("t6_test_mode", 32'(test_mode_o), 1);
    check("t6_cause", 32'(rst_cause_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
